// File: rtl/alu_share_pkg.sv
// Shared encodings for the two-requester ALU sequencer and its command decoder.
package alu_share_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned AS_W   = 4;
  localparam int unsigned AO_W   = 2;
  localparam int unsigned LO_W   = 4;
  localparam int unsigned SRO_W  = 4;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'd0,
    UNIT_LOGIC = 2'd1,
    UNIT_SHIFT = 2'd2,
    UNIT_SLT   = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [AS_W-1:0] AS_ARITH = AS_W'(0);
  localparam logic [AS_W-1:0] AS_LOGIC = AS_W'(1);
  localparam logic [AS_W-1:0] AS_SHIFT = AS_W'(2);
  localparam logic [AS_W-1:0] AS_SLT   = AS_W'(3);

  localparam logic [AO_W-1:0] AO_ADD = AO_W'(0);
  localparam logic [AO_W-1:0] AO_SUB = AO_W'(1);

  typedef struct packed {
    logic [AS_W-1:0]  as;
    logic [AO_W-1:0]  ao;
    logic [LO_W-1:0]  lo;
    logic [SRO_W-1:0] sro;
  } alu_sel_t;

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational command {unit, sub} to ALU select decode; unselected fields are zero.
module alu_cmd_decode
  import alu_share_pkg::*;
(
  input  logic [CMD_W-1:0] cmd_i,
  output alu_sel_t         sel_o
);

  unit_e unit;
  assign unit = unit_e'(cmd_i[3:2]);

  always_comb begin
    sel_o = '0;
    case (unit)
      UNIT_ARITH: begin
        sel_o.as = AS_ARITH;
        sel_o.ao = cmd_i[0] ? AO_SUB : AO_ADD;
      end
      UNIT_LOGIC: begin
        sel_o.as = AS_LOGIC;
        sel_o.lo = LO_W'(cmd_i[1:0]);
      end
      UNIT_SHIFT: begin
        sel_o.as  = AS_SHIFT;
        sel_o.sro = SRO_W'(cmd_i[1:0]);
      end
      UNIT_SLT:   sel_o.as = AS_SLT;
      default:    sel_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer for a shared combinational ALU (IDLE -> EXEC -> RESP).
// Optional perf counters under `ALU_SHARE_PERF_CNT_EN.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREQ_LOG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [CMD_W-1:0] req0_cmd,
  input  logic [CMD_W-1:0] req1_cmd,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_of,
  output logic             resp_zf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [AS_W-1:0]  alu_as,
  output logic [LO_W-1:0]  alu_lo,
  output logic [SRO_W-1:0] alu_sro,
  output logic [AO_W-1:0]  alu_ao,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_of,
  input  logic             alu_zf
`ifdef ALU_SHARE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_grant0,
  output logic [31:0]      perf_grant1,
  output logic [31:0]      perf_contend
`endif
);

  if (NREQ_LOG != 1) begin : g_nreq_check
    $error("alu_share_ctrl supports exactly two requesters (NREQ_LOG must be 1)");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             of_q, of_d, zf_q, zf_d;
  logic             owner_q, owner_d, last_q, last_d;
  alu_sel_t         sel_q, sel_d, dec_sel;
  logic             grant;
  logic [CMD_W-1:0] grant_cmd;

  // Sole valid port wins; on contention the port not granted last time wins.
  assign grant     = (&req_valid) ? ~last_q : req_valid[1];
  assign grant_cmd = grant ? req1_cmd : req0_cmd;

  alu_cmd_decode u_dec (
    .cmd_i (grant_cmd),
    .sel_o (dec_sel)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    owner_d   = owner_q;
    last_d    = last_q;
    result_d  = result_q;
    of_d      = of_q;
    zf_d      = zf_q;
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if (!reset && (|req_valid)) begin
          req_ready[grant] = 1'b1;
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          sel_d   = dec_sel;
          owner_d = grant;
          last_d  = grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        of_d     = alu_of;
        zf_d     = alu_zf;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
      of_q     <= of_d;
      zf_q     <= zf_d;
    end
  end

  // ALU inputs come straight from the latch: stable outside EXEC, no mux glitches.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_as      = sel_q.as;
  assign alu_ao      = sel_q.ao;
  assign alu_lo      = sel_q.lo;
  assign alu_sro     = sel_q.sro;
  assign resp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_result = result_q;
  assign resp_of     = of_q;
  assign resp_zf     = zf_q;

`ifdef ALU_SHARE_PERF_CNT_EN
  logic [31:0] grant0_q, grant1_q, contend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_q  <= '0;
      grant1_q  <= '0;
      contend_q <= '0;
    end else if (state_q == IDLE) begin
      if (req_valid[0] && !grant) grant0_q <= grant0_q + 32'd1;
      if (req_valid[1] && grant)  grant1_q <= grant1_q + 32'd1;
      if (&req_valid)             contend_q <= contend_q + 32'd1;
    end
  end

  assign perf_grant0  = grant0_q;
  assign perf_grant1  = grant1_q;
  assign perf_contend = contend_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural stand-in for the shared ALU.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0]  req0_cmd, req1_cmd;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [31:0] resp_result, alu_a, alu_b, alu_result;
  logic        resp_of, resp_zf, alu_of, alu_zf;
  logic [3:0]  alu_as, alu_lo, alu_sro;
  logic [1:0]  alu_ao;
`ifdef ALU_SHARE_PERF_CNT_EN
  logic [31:0] perf_grant0, perf_grant1, perf_contend;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32), .NREQ_LOG(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_of(resp_of), .resp_zf(resp_zf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_as(alu_as), .alu_lo(alu_lo),
    .alu_sro(alu_sro), .alu_ao(alu_ao),
    .alu_result(alu_result), .alu_of(alu_of), .alu_zf(alu_zf)
`ifdef ALU_SHARE_PERF_CNT_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_contend(perf_contend)
`endif
  );

  // Reference MIPS-style ALU: AS 0 arith, 1 logic, 2 shift, 3 slt.
  always_comb begin
    alu_result = 32'd0;
    alu_of     = 1'b0;
    case (alu_as)
      4'd0: begin
        if (alu_ao == 2'd1) begin
          alu_result = alu_a - alu_b;
          alu_of = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
        end else begin
          alu_result = alu_a + alu_b;
          alu_of = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
        end
      end
      4'd1: case (alu_lo)
        4'd0:    alu_result = alu_a & alu_b;
        4'd1:    alu_result = alu_a | alu_b;
        4'd2:    alu_result = alu_a ^ alu_b;
        4'd3:    alu_result = ~(alu_a | alu_b);
        default: alu_result = 32'd0;
      endcase
      4'd2: case (alu_sro)
        4'd0:    alu_result = alu_a << alu_b[4:0];
        4'd1:    alu_result = alu_a >> alu_b[4:0];
        4'd2:    alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
        4'd3:    alu_result = (alu_a >> alu_b[4:0]) | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}));
        default: alu_result = 32'd0;
      endcase
      4'd3:    alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zf = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    if (p == 1) begin
      req1_cmd = cmd; req1_a = a; req1_b = b;
    end else begin
      req0_cmd = cmd; req0_a = a; req0_b = b;
    end
  endtask

  // One uncontended op: accept, EXEC select check, response check, handshake.
  task automatic do_op(input int p, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eo, input logic ez,
                       input logic [3:0] eas, input logic [1:0] eao, input logic [3:0] elo,
                       input logic [3:0] esro);
    logic [1:0] oh;
    int n;
    oh = (p == 1) ? 2'b10 : 2'b01;
    tick();
    drive_port(p, cmd, a, b);
    req_valid[p] = 1'b1;
    #1;
    n = 0;
    while (req_ready[p] !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (n == 8) check("accept_timeout", 32'd0, 32'd1);
    check("req_ready", 32'(req_ready), 32'(oh));
    tick();
    req_valid[p] = 1'b0;
    check("exec_resp_valid", 32'(resp_valid), 32'd0);
    check("exec_req_ready", 32'(req_ready), 32'd0);
    check("exec_as", 32'(alu_as), 32'(eas));
    check("exec_ao", 32'(alu_ao), 32'(eao));
    check("exec_lo", 32'(alu_lo), 32'(elo));
    check("exec_sro", 32'(alu_sro), 32'(esro));
    check("exec_a", alu_a, a);
    check("exec_b", alu_b, b);
    tick();
    check("resp_valid", 32'(resp_valid), 32'(oh));
    check("resp_result", resp_result, er);
    check("resp_of", 32'(resp_of), 32'(eo));
    check("resp_zf", 32'(resp_zf), 32'(ez));
    resp_ready[p] = 1'b1;
    tick();
    resp_ready = 2'b00;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_oh;
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    drive_port(0, 4'h0, 32'd0, 32'd0);
    drive_port(1, 4'h0, 32'd0, 32'd0);
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_flags", 32'({resp_of, resp_zf}), 32'd0);
    check("rst_alu_ab", alu_a | alu_b, 32'd0);
    check("rst_alu_sel", 32'({alu_as, alu_ao, alu_lo, alu_sro}), 32'd0);
    reset = 1'b0;

    // Arithmetic: basic add, signed overflow, zero from subtract.
    do_op(0, 4'h0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 4'd0);
    do_op(0, 4'h0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0, 4'd0, 2'd0, 4'd0, 4'd0);
    do_op(0, 4'h1, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 4'd0, 2'd1, 4'd0, 4'd0);
    // Logic unit, every sub.
    do_op(1, 4'h4, 32'h8000_00F0, 32'h0000_0F04, 32'h0000_0000, 1'b0, 1'b1, 4'd1, 2'd0, 4'd0, 4'd0);
    do_op(1, 4'h5, 32'h8000_00F0, 32'h0000_0F04, 32'h8000_0FF4, 1'b0, 1'b0, 4'd1, 2'd0, 4'd1, 4'd0);
    do_op(0, 4'h6, 32'h8000_00F0, 32'h0000_0F04, 32'h8000_0FF4, 1'b0, 1'b0, 4'd1, 2'd0, 4'd2, 4'd0);
    do_op(1, 4'h7, 32'h8000_00F0, 32'h0000_0F04, 32'h7FFF_F00B, 1'b0, 1'b0, 4'd1, 2'd0, 4'd3, 4'd0);
    // Shift unit, every sub (shift amount 4).
    do_op(1, 4'h8, 32'h8000_00F0, 32'h0000_0F04, 32'h0000_0F00, 1'b0, 1'b0, 4'd2, 2'd0, 4'd0, 4'd0);
    do_op(0, 4'h9, 32'h8000_00F0, 32'h0000_0F04, 32'h0800_000F, 1'b0, 1'b0, 4'd2, 2'd0, 4'd0, 4'd1);
    do_op(1, 4'hA, 32'h8000_00F0, 32'h0000_0F04, 32'hF800_000F, 1'b0, 1'b0, 4'd2, 2'd0, 4'd0, 4'd2);
    do_op(0, 4'hB, 32'h8000_00F0, 32'h0000_0F04, 32'h0800_000F, 1'b0, 1'b0, 4'd2, 2'd0, 4'd0, 4'd3);
    // SLT, every sub (sub is ignored).
    do_op(1, 4'hC, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0, 4'd3, 2'd0, 4'd0, 4'd0);
    do_op(0, 4'hD, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 4'd3, 2'd0, 4'd0, 4'd0);
    do_op(1, 4'hE, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0, 4'd3, 2'd0, 4'd0, 4'd0);
    do_op(0, 4'hF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'd3, 2'd0, 4'd0, 4'd0);

    // Response backpressure with a competing request and a stray non-owner resp_ready.
    tick();
    drive_port(0, 4'h5, 32'h8000_00F0, 32'h0000_0F04);
    req_valid = 2'b01;
    #1;
    check("bp_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b10;
    drive_port(1, 4'h0, 32'd3, 32'd4);
    #1;
    check("bp_exec_ready", 32'(req_ready), 32'd0);
    tick();
    resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_result", resp_result, 32'h8000_0FF4);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    check("bp_release", 32'(resp_valid), 32'd0);
    check("bp_resume", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    tick();
    check("bp_r1_valid", 32'(resp_valid), 32'd2);
    check("bp_r1_result", resp_result, 32'd7);
    resp_ready = 2'b10;
    tick();
    resp_ready = 2'b00;
    check("bp_r1_drop", 32'(resp_valid), 32'd0);
    check("hold_alu_a", alu_a, 32'd3);

    // Reset while in EXEC discards the op.
    tick();
    drive_port(0, 4'h0, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    check("rx_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    check("rx_exec_a", alu_a, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rx_resp_valid", 32'(resp_valid), 32'd0);
    check("rx_alu_a", alu_a, 32'd0);
    check("rx_alu_sel", 32'({alu_as, alu_ao, alu_lo, alu_sro}), 32'd0);
    check("rx_result", resp_result, 32'd0);
    tick();
    check("rx_no_resp", 32'(resp_valid), 32'd0);
    do_op(1, 4'h0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 4'd0, 2'd0, 4'd0, 4'd0);

    // Continuous contention: grants alternate starting at port 0.
    tick();
    drive_port(0, 4'h0, 32'd1, 32'd1);
    drive_port(1, 4'h0, 32'd2, 32'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      exp_oh = (k % 2 == 1) ? 2'b10 : 2'b01;
      n = 0;
      while (resp_valid === 2'b00 && n < 10) begin
        tick();
        n++;
      end
      if (n == 10) check("cont_timeout", 32'd0, 32'd1);
      check("cont_grant", 32'(resp_valid), 32'(exp_oh));
      check("cont_result", resp_result, (k % 2 == 1) ? 32'd4 : 32'd2);
      resp_ready = 2'b11;
      if (k == 5) req_valid = 2'b00;
      tick();
      resp_ready = 2'b00;
    end
`ifdef ALU_SHARE_PERF_CNT_EN
    check("perf_grant0", perf_grant0, 32'd3);
    check("perf_grant1", perf_grant1, 32'd4);
    check("perf_contend", perf_contend, 32'd6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
